// File: rtl/coin_acceptor_if.sv
// Signal bundle between the coin acceptor and its user/controller side.
// The master drives the sensor, user and controller inputs; the slave is the acceptor.
interface coin_acceptor_if #(
    parameter int unsigned CREDIT_W = 4
);
    logic                coin_raw;
    logic [1:0]          coin_value;
    logic                double_sel;
    logic                cancel;
    logic                wash_done;
    logic                coin_in;
    logic                double_wash;
    logic [CREDIT_W-1:0] credit;
    logic                coin_reject;
    logic                refund_pulse;
    logic [CREDIT_W-1:0] refund_amt;
    logic                busy;

    modport master (
        output coin_raw, coin_value, double_sel, cancel, wash_done,
        input  coin_in, double_wash, credit, coin_reject, refund_pulse, refund_amt, busy
    );

    modport slave (
        input  coin_raw, coin_value, double_sel, cancel, wash_done,
        output coin_in, double_wash, credit, coin_reject, refund_pulse, refund_amt, busy
    );
endinterface

// File: rtl/coin_acceptor.sv
// Washing-machine payment front-end: debounces coins, accumulates credit,
// starts the wash when paid and the controller is idle, refunds change/cancel/timeout.
module coin_acceptor #(
    parameter int unsigned PRICE_SINGLE = 4,
    parameter int unsigned PRICE_DOUBLE = 6,
    parameter int unsigned CREDIT_W     = 4,
    parameter int unsigned DEBOUNCE_CYC = 4,
    parameter int unsigned TIMEOUT_CYC  = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    coin_acceptor_if.slave   bus
);
    localparam int unsigned DEB_W = $clog2(DEBOUNCE_CYC + 2);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        START   = 3'd2,
        RUN     = 3'd3,
        REFUND  = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic                sync1_q, sync2_q;
    logic [DEB_W-1:0]    deb_q, deb_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CREDIT_W-1:0] change_q, change_d;
    logic [CREDIT_W-1:0] refund_amt_q, refund_amt_d;
    logic                seen_busy_q, seen_busy_d;
    logic                double_wash_q, double_wash_d;
    logic                coin_reject_q, coin_reject_d;
    logic                coin_in_q, busy_q, refund_pulse_q;

    logic                accept_c;
    logic                invalid_c;
    logic                reload_c;
    logic [2:0]          coin_units_c;
    logic [CREDIT_W:0]   sum_c;
    logic [CREDIT_W-1:0] credit_new_c;
    logic [CREDIT_W-1:0] price_c;

    // Debounce: count consecutive synchronised-high cycles, saturating one past the accept point
    always_comb begin
        deb_d = deb_q;
        if (!sync2_q) begin
            deb_d = '0;
        end else if (deb_q != DEB_W'(DEBOUNCE_CYC + 1)) begin
            deb_d = deb_q + DEB_W'(1);
        end
    end

    assign accept_c  = (deb_q == DEB_W'(DEBOUNCE_CYC));
    assign invalid_c = (bus.coin_value == 2'b11);
    assign price_c   = bus.double_sel ? CREDIT_W'(PRICE_DOUBLE) : CREDIT_W'(PRICE_SINGLE);

    always_comb begin
        case (bus.coin_value)
            2'b00:   coin_units_c = 3'd1;
            2'b01:   coin_units_c = 3'd2;
            2'b10:   coin_units_c = 3'd4;
            default: coin_units_c = 3'd0;
        endcase
    end

    assign sum_c = {1'b0, credit_q} + (CREDIT_W + 1)'(coin_units_c);

    // Next-state, credit bookkeeping and registered-output next values
    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        change_d      = change_q;
        tmo_d         = tmo_q;
        seen_busy_d   = seen_busy_q;
        refund_amt_d  = refund_amt_q;
        double_wash_d = double_wash_q;
        coin_reject_d = 1'b0;
        credit_new_c  = credit_q;
        reload_c      = 1'b0;

        if (accept_c) begin
            if (invalid_c || sum_c[CREDIT_W] || !(state_q inside {IDLE, COLLECT})) begin
                coin_reject_d = 1'b1;
            end else begin
                credit_new_c = sum_c[CREDIT_W-1:0];
                reload_c     = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                credit_d      = '0;
                double_wash_d = 1'b0;
                if (reload_c) begin
                    credit_d = credit_new_c;
                    tmo_d    = '0;
                    state_d  = COLLECT;
                end
            end
            COLLECT: begin
                credit_d = credit_new_c;
                tmo_d    = reload_c ? '0 : tmo_q + TMO_W'(1);
                if (bus.cancel || (!reload_c && tmo_q == TMO_W'(TIMEOUT_CYC - 1))) begin
                    state_d      = REFUND;
                    refund_amt_d = credit_new_c;
                    credit_d     = '0;
                    tmo_d        = '0;
                end else if (credit_q >= price_c && bus.wash_done) begin
                    state_d       = START;
                    change_d      = credit_new_c - price_c;
                    credit_d      = '0;
                    tmo_d         = '0;
                    double_wash_d = bus.double_sel;
                    seen_busy_d   = 1'b0;
                end
            end
            START: begin
                state_d = RUN;
            end
            RUN: begin
                // The controller must be seen busy before its idle level ends the wash
                if (!bus.wash_done) begin
                    seen_busy_d = 1'b1;
                end else if (seen_busy_q) begin
                    double_wash_d = 1'b0;
                    seen_busy_d   = 1'b0;
                    if (change_q != '0) begin
                        state_d      = REFUND;
                        refund_amt_d = change_q;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            REFUND: begin
                credit_d = '0;
                change_d = '0;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            sync1_q        <= 1'b0;
            sync2_q        <= 1'b0;
            deb_q          <= '0;
            tmo_q          <= '0;
            credit_q       <= '0;
            change_q       <= '0;
            refund_amt_q   <= '0;
            seen_busy_q    <= 1'b0;
            double_wash_q  <= 1'b0;
            coin_reject_q  <= 1'b0;
            coin_in_q      <= 1'b0;
            busy_q         <= 1'b0;
            refund_pulse_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            sync1_q        <= bus.coin_raw;
            sync2_q        <= sync1_q;
            deb_q          <= deb_d;
            tmo_q          <= tmo_d;
            credit_q       <= credit_d;
            change_q       <= change_d;
            refund_amt_q   <= refund_amt_d;
            seen_busy_q    <= seen_busy_d;
            double_wash_q  <= double_wash_d;
            coin_reject_q  <= coin_reject_d;
            coin_in_q      <= (state_d == START);
            busy_q         <= (state_d == START) || (state_d == RUN);
            refund_pulse_q <= (state_d == REFUND);
        end
    end

    assign bus.coin_in      = coin_in_q;
    assign bus.double_wash  = double_wash_q;
    assign bus.credit       = credit_q;
    assign bus.coin_reject  = coin_reject_q;
    assign bus.refund_pulse = refund_pulse_q;
    assign bus.refund_amt   = refund_amt_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: purchase, change, cancel, timeout, reject,
// debounce, busy-controller and reset scenarios with hand-computed expectations.
module tb_coin_acceptor;
    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    coin_acceptor_if #(.CREDIT_W(4)) bus ();

    coin_acceptor #(
        .PRICE_SINGLE(4),
        .PRICE_DOUBLE(6),
        .CREDIT_W    (4),
        .DEBOUNCE_CYC(4),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Returns just after the edge at which the coin is accepted (credit visible)
    task automatic coin(input logic [1:0] v);
        bus.coin_value = v;
        bus.coin_raw   = 1'b1;
        repeat (7) tick();
        bus.coin_raw   = 1'b0;
    endtask

    task automatic gap();
        repeat (3) tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_coin_in"},      32'(bus.coin_in),      0);
        chk({tag, "_double_wash"},  32'(bus.double_wash),  0);
        chk({tag, "_credit"},       32'(bus.credit),       0);
        chk({tag, "_coin_reject"},  32'(bus.coin_reject),  0);
        chk({tag, "_refund_pulse"}, 32'(bus.refund_pulse), 0);
        chk({tag, "_refund_amt"},   32'(bus.refund_amt),   0);
        chk({tag, "_busy"},         32'(bus.busy),         0);
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        rst_n          = 1'b0;
        bus.coin_raw   = 1'b0;
        bus.coin_value = 2'b00;
        bus.double_sel = 1'b0;
        bus.cancel     = 1'b0;
        bus.wash_done  = 1'b1;
        repeat (3) tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Two-cycle glitch never reaches the debounce threshold
        bus.coin_raw = 1'b1;
        repeat (2) tick();
        bus.coin_raw = 1'b0;
        repeat (8) tick();
        chk("glitch_credit", 32'(bus.credit), 0);
        chk("glitch_reject", 32'(bus.coin_reject), 0);

        // Single wash at exact price with four 1-unit coins
        coin(2'b00); chk("single_c1", 32'(bus.credit), 1); gap();
        coin(2'b00); chk("single_c2", 32'(bus.credit), 2); gap();
        coin(2'b00); chk("single_c3", 32'(bus.credit), 3); gap();
        coin(2'b00); chk("single_c4", 32'(bus.credit), 4);
        chk("single_no_start_yet", 32'(bus.coin_in), 0);
        tick();
        chk("single_coin_in", 32'(bus.coin_in), 1);
        chk("single_dw", 32'(bus.double_wash), 0);
        chk("single_busy", 32'(bus.busy), 1);
        chk("single_credit_clr", 32'(bus.credit), 0);
        tick();
        chk("single_coin_in_1cyc", 32'(bus.coin_in), 0);
        bus.wash_done = 1'b0;
        repeat (2) tick();
        bus.wash_done = 1'b1;
        tick();
        chk("single_done_busy", 32'(bus.busy), 0);
        chk("single_no_refund", 32'(bus.refund_pulse), 0);
        tick();
        chk("single_no_refund2", 32'(bus.refund_pulse), 0);

        // Double wash with 2 units of change
        bus.double_sel = 1'b1;
        coin(2'b10); chk("double_c1", 32'(bus.credit), 4);
        tick();
        chk("double_below_price", 32'(bus.busy), 0);
        repeat (2) tick();
        coin(2'b10); chk("double_c2", 32'(bus.credit), 8);
        tick();
        chk("double_coin_in", 32'(bus.coin_in), 1);
        chk("double_dw", 32'(bus.double_wash), 1);
        tick();
        chk("double_dw_held", 32'(bus.double_wash), 1);
        tick();
        chk("double_run_needs_seen_busy", 32'(bus.busy), 1);
        bus.wash_done = 1'b0;
        tick();
        bus.wash_done = 1'b1;
        tick();
        chk("double_refund_pulse", 32'(bus.refund_pulse), 1);
        chk("double_refund_amt", 32'(bus.refund_amt), 2);
        chk("double_dw_cleared", 32'(bus.double_wash), 0);
        tick();
        chk("double_refund_1cyc", 32'(bus.refund_pulse), 0);
        chk("double_refund_amt_held", 32'(bus.refund_amt), 2);
        bus.double_sel = 1'b0;

        // Cancel after a 2-unit coin
        coin(2'b01); chk("cancel_credit", 32'(bus.credit), 2);
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        chk("cancel_pulse", 32'(bus.refund_pulse), 1);
        chk("cancel_amt", 32'(bus.refund_amt), 2);
        chk("cancel_credit_clr", 32'(bus.credit), 0);
        chk("cancel_no_coin_in", 32'(bus.coin_in), 0);
        tick();

        // Cancel in the same cycle as a 2-unit accept on top of 2 units
        coin(2'b01); chk("cancel2_credit", 32'(bus.credit), 2); gap();
        bus.coin_value = 2'b01;
        bus.coin_raw   = 1'b1;
        repeat (6) tick();
        bus.cancel = 1'b1;
        tick();
        bus.cancel   = 1'b0;
        bus.coin_raw = 1'b0;
        chk("cancel2_pulse", 32'(bus.refund_pulse), 1);
        chk("cancel2_amt", 32'(bus.refund_amt), 4);
        chk("cancel2_credit_clr", 32'(bus.credit), 0);
        tick();

        // Timeout refunds exactly 16 cycles after the credit update
        coin(2'b00);
        repeat (15) tick();
        chk("tmo_before", 32'(bus.refund_pulse), 0);
        tick();
        chk("tmo_pulse", 32'(bus.refund_pulse), 1);
        chk("tmo_amt", 32'(bus.refund_amt), 1);
        tick();

        // A coin 10 cycles in reloads the timer
        coin(2'b00);
        gap();
        coin(2'b00);
        chk("tmo_reload_credit", 32'(bus.credit), 2);
        repeat (15) tick();
        chk("tmo_reload_before", 32'(bus.refund_pulse), 0);
        chk("tmo_reload_still_credit", 32'(bus.credit), 2);
        tick();
        chk("tmo_reload_pulse", 32'(bus.refund_pulse), 1);
        chk("tmo_reload_amt", 32'(bus.refund_amt), 2);
        tick();

        // Invalid denomination
        coin(2'b00); gap();
        coin(2'b11);
        chk("inv_reject", 32'(bus.coin_reject), 1);
        chk("inv_credit", 32'(bus.credit), 1);
        tick();
        chk("inv_reject_1cyc", 32'(bus.coin_reject), 0);
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        chk("inv_cancel_amt", 32'(bus.refund_amt), 1);
        tick();

        // Busy controller blocks start; overflow beyond 15 is rejected
        bus.wash_done = 1'b0;
        coin(2'b10); chk("ovf_c1", 32'(bus.credit), 4); gap();
        chk("busy_ctrl_no_start", 32'(bus.coin_in), 0);
        coin(2'b10); chk("ovf_c2", 32'(bus.credit), 8); gap();
        coin(2'b10); chk("ovf_c3", 32'(bus.credit), 12); gap();
        chk("busy_ctrl_still_collect", 32'(bus.busy), 0);
        coin(2'b10);
        chk("ovf_reject", 32'(bus.coin_reject), 1);
        chk("ovf_credit", 32'(bus.credit), 12);
        bus.wash_done = 1'b1;
        tick();
        chk("ovf_start", 32'(bus.coin_in), 1);
        tick();

        // Coin during RUN is rejected, then reset mid-wash
        coin(2'b00);
        chk("run_reject", 32'(bus.coin_reject), 1);
        chk("run_busy", 32'(bus.busy), 1);
        chk("run_credit", 32'(bus.credit), 0);
        rst_n = 1'b0;
        #1;
        chk_all_zero("run_reset");
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_reset_busy", 32'(bus.busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/coin_acceptor.md
# coin_acceptor

Payment front-end for the washing-machine controller. It debounces the coin-mech sensor and accumulates credit in coin units. When the price for the selected programme is covered and the controller reports idle, it issues the one-cycle `coin_in` start pulse with a held `double_wash` select. It tracks the wash through `wash_done` and refunds change, cancelled credit or timed-out credit.

## Interface
Parameters:
- PRICE_SINGLE, 4, single-wash price in coin units
- PRICE_DOUBLE, 6, double-wash price in coin units
- CREDIT_W, 4, credit/refund width; credit saturates at 2^CREDIT_W-1
- DEBOUNCE_CYC, 4, consecutive synchronised-high cycles required to accept a coin (≥1)
- TIMEOUT_CYC, 1000, idle cycles in COLLECT before partial credit is refunded

Ports (reset rst_n, asynchronous, active-low; clock clk):
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- coin_raw  in  1  asynchronous coin sensor, high while a coin passes
- coin_value  in  2  denomination: 00=1, 01=2, 10=4, 11=invalid; sampled at acceptance
- double_sel  in  1  user programme select, synchronous
- cancel  in  1  synchronous refund request, level
- wash_done  in  1  from controller; high = idle
- coin_in  out  1  one-cycle start pulse to controller
- double_wash  out  1  programme select to controller, held from START through RUN
- credit  out  CREDIT_W  current credit
- coin_reject  out  1  one-cycle pulse, accepted-edge coin rejected
- refund_pulse  out  1  one-cycle refund strobe
- refund_amt  out  CREDIT_W  refund value, valid with refund_pulse, held until next refund
- busy  out  1  high in START and RUN

## Operation
- Input path: coin_raw passes through a 2-flop synchroniser, then a counter of consecutive high cycles. The accept strobe fires once when the count reaches DEBOUNCE_CYC. No new accept until the synchronised level has been low ≥1 cycle.
- price = double_sel ? PRICE_DOUBLE : PRICE_SINGLE, evaluated every cycle.
- IDLE: credit=0. A valid accept loads credit=value and moves to COLLECT.
- COLLECT:
  - A valid accept adds value to credit and reloads the timeout counter.
  - If the sum exceeds the maximum, credit is unchanged and coin_reject pulses.
  - Priority order: cancel → REFUND (amount = credit including a same-cycle coin); then timeout expiry → REFUND; then credit ≥ price and wash_done=1 → START.
  - With credit ≥ price but wash_done=0, stay in COLLECT; the timer still runs.
- START (1 cycle):
  - coin_in=1.
  - double_wash latched from double_sel.
  - change register = credit − price.
  - credit cleared.
  - → RUN.
- RUN:
  - Set seen_busy when wash_done=0.
  - When wash_done=1 with seen_busy set: → REFUND if change>0, else → IDLE.
  - double_wash is cleared on exit.
- REFUND (1 cycle):
  - refund_pulse=1, refund_amt=amount.
  - credit=0, change=0.
  - → IDLE.
- Reject rules:
  - coin_value=11 in any state: coin_reject pulses, credit unchanged.
  - Any accept in START, RUN or REFUND: coin_reject pulses.
  - cancel is ignored in START and RUN.
- Arithmetic: additions use CREDIT_W+1 bits to detect overflow. Subtraction is only performed when credit ≥ price, so it never wraps.

## Timing
- Reset values: coin_in 0, double_wash 0, credit 0, coin_reject 0, refund_pulse 0, refund_amt 0, busy 0. State is IDLE; debounce and timeout counters are 0.
- Coin latency: if coin_raw is first sampled high at edge 0, the credit/coin_reject update is visible after edge DEBOUNCE_CYC+2, i.e. 6 edges with the default.
- COLLECT→START takes 1 cycle after the condition holds. coin_in is high for exactly one cycle. double_wash is valid in the same cycle as coin_in.
- Timeout: TIMEOUT_CYC consecutive COLLECT cycles with no accepted coin trigger REFUND on the next edge.
- wash_done=1 on the cycle after START does not end RUN; seen_busy is required first.
- Reset mid-operation (any state) returns to reset values immediately. Lost credit is not refunded.

## Test plan
- Single wash, exact price: four coin_value=00 coins, double_sel=0, wash_done=1 → credit 1,2,3,4. coin_in pulses once with double_wash=0. No refund after wash_done falls and rises.
- Double wash with change: coins 4 then 4, double_sel=1 → credit 8. START with double_wash=1. After the wash completes, refund_pulse with refund_amt=2.
- Cancel: coin 2 then cancel → refund_pulse with refund_amt=2, credit 0, no coin_in. Cancel in the same cycle as a coin-2 accept (credit 2) → refund_amt=4.
- Timeout: one coin 1, TIMEOUT_CYC=16 → refund_amt=1 exactly 16 cycles after credit update. A coin at cycle 10 reloads the timer.
- Rejects: coin_value=11 → coin_reject, credit unchanged. A coin during RUN → coin_reject. Credit 12 (CREDIT_W=4) plus coin 4 → coin_reject, credit stays 12.
- Debounce and busy controller: a coin_raw glitch 2 cycles wide (DEBOUNCE_CYC=4) → no credit. Credit ≥ price with wash_done=0 → no coin_in until wash_done=1. Reset asserted in RUN → all outputs 0.
